// File: rtl/rot_cmd_fifo.sv
// Show-ahead command queue feeding the 8-bit rotate-left stage.
// Head entry is presented combinationally on sh_a/sh_amt; empty forces them to zero.
module rot_cmd_fifo #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,
  input  logic [2:0]        in_amt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        sh_a,
  output logic [2:0]        sh_amt,
  output logic [ADDR_W:0]   level
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  if ((DEPTH < 2) || (DEPTH != (1 << ADDR_W))) begin : g_param_check
    $error("rot_cmd_fifo: DEPTH must be a power of 2 >= 2 and equal 2**ADDR_W");
  end

  logic [10:0]       r_mem [DEPTH];
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W:0]   r_count;

  logic              w_push;
  logic              w_pop;
  logic [10:0]       w_head;

  assign in_ready  = (r_count != FULL_CNT);
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;
  assign level     = r_count;

  // Unwritten slots may hold X, so the head is gated to zero while empty.
  assign w_head = out_valid ? r_mem[r_rd_ptr] : 11'd0;
  assign sh_a   = w_head[7:0];
  assign sh_amt = w_head[10:8];

  always_ff @(posedge clk) begin
    if (w_push && !flush) begin
      r_mem[r_wr_ptr] <= {in_amt, in_data};
    end
  end

  // Flush outranks any push/pop presented in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (ADDR_W+1)'(1);
        2'b01:   r_count <= r_count - (ADDR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_rot_cmd_fifo.sv
// Directed bench for rot_cmd_fifo: reset, order, full, simultaneous, flush, async reset.
module tb_rot_cmd_fifo;

  logic       clk;
  logic       reset_n;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [2:0] in_amt;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] sh_a;
  logic [2:0] sh_amt;
  logic [2:0] level;

  int vec;
  int miss;

  rot_cmd_fifo #(.DEPTH(4), .ADDR_W(2)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sh_a      (sh_a),
    .sh_amt    (sh_amt),
    .level     (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Rotate stage driven by the head outputs
  function automatic logic [7:0] rol8(input logic [7:0] a, input logic [2:0] amt);
    logic [15:0] t;
    t = {a, a} << amt;
    return t[15:8];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = 8'h00; in_amt = 3'd0;
    step();
    vec++; if (out_valid !== 1'b0) begin miss++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    vec++; if (in_ready !== 1'b1) begin miss++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    vec++; if (level !== 3'd0) begin miss++; $display("FAIL reset_level got %0d want 0", level); end
    vec++; if (sh_a !== 8'h00 || sh_amt !== 3'd0) begin miss++; $display("FAIL reset_head got %h/%0d want 00/0", sh_a, sh_amt); end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    in_valid = 1'b1; in_data = 8'h81; in_amt = 3'd1;
    vec++; if (out_valid !== 1'b0) begin miss++; $display("FAIL basic_no_bypass got %b want 0", out_valid); end
    step();
    in_valid = 1'b0;
    vec++; if (out_valid !== 1'b1) begin miss++; $display("FAIL basic_out_valid got %b want 1", out_valid); end
    vec++; if (sh_a !== 8'h81 || sh_amt !== 3'd1) begin miss++; $display("FAIL basic_head got %h/%0d want 81/1", sh_a, sh_amt); end
    vec++; if (rol8(sh_a, sh_amt) !== 8'h03) begin miss++; $display("FAIL basic_rot got %h want 03", rol8(sh_a, sh_amt)); end
    vec++; if (level !== 3'd1) begin miss++; $display("FAIL basic_level got %0d want 1", level); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    vec++; if (out_valid !== 1'b0) begin miss++; $display("FAIL basic_pop_valid got %b want 0", out_valid); end
    vec++; if (sh_a !== 8'h00 || level !== 3'd0) begin miss++; $display("FAIL basic_pop_state got %h/%0d want 00/0", sh_a, level); end
  endtask

  task automatic test_fill();
    logic [7:0] exp_a [4];
    logic [7:0] exp_y [4];
    exp_a = '{8'h01, 8'h02, 8'h04, 8'h08};
    exp_y = '{8'h01, 8'h04, 8'h10, 8'h40};
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = exp_a[i]; in_amt = 3'(i);
      step();
    end
    in_valid = 1'b0;
    vec++; if (level !== 3'd4 || in_ready !== 1'b0) begin miss++; $display("FAIL fill_full got lvl %0d rdy %b want 4/0", level, in_ready); end
    in_valid = 1'b1; in_data = 8'hFF; in_amt = 3'd7;
    step();
    in_valid = 1'b0;
    vec++; if (level !== 3'd4 || sh_a !== 8'h01) begin miss++; $display("FAIL fill_reject got lvl %0d head %h want 4/01", level, sh_a); end
    for (int i = 0; i < 4; i++) begin
      vec++;
      if (sh_a !== exp_a[i] || sh_amt !== 3'(i) || rol8(sh_a, sh_amt) !== exp_y[i]) begin
        miss++;
        $display("FAIL drain_%0d got %h/%0d y %h want %h/%0d y %h", i, sh_a, sh_amt, rol8(sh_a, sh_amt), exp_a[i], i, exp_y[i]);
      end
      out_ready = 1'b1;
      step();
    end
    out_ready = 1'b0;
    vec++; if (out_valid !== 1'b0 || level !== 3'd0) begin miss++; $display("FAIL drain_empty got vld %b lvl %0d want 0/0", out_valid, level); end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = 8'hA0 + 8'(i); in_amt = 3'(i);
      step();
    end
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; out_ready = 1'b1;
      in_data = 8'hA2 + 8'(i); in_amt = 3'(i + 2);
      vec++;
      if (sh_a !== 8'hA0 + 8'(i) || sh_amt !== 3'(i)) begin
        miss++;
        $display("FAIL simul_head_%0d got %h/%0d want %h/%0d", i, sh_a, sh_amt, 8'hA0 + 8'(i), i);
      end
      step();
      vec++; if (level !== 3'd2) begin miss++; $display("FAIL simul_level_%0d got %0d want 2", i, level); end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    vec++; if (sh_a !== 8'hA6 || sh_amt !== 3'd6) begin miss++; $display("FAIL simul_final_head got %h/%0d want A6/6", sh_a, sh_amt); end
  endtask

  task automatic test_full_pop();
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = 8'hB0 + 8'(i); in_amt = 3'd5;
      step();
    end
    vec++; if (level !== 3'd4 || in_ready !== 1'b0) begin miss++; $display("FAIL fullpop_pre got lvl %0d rdy %b want 4/0", level, in_ready); end
    in_valid = 1'b1; in_data = 8'hCC; out_ready = 1'b1;
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    vec++; if (level !== 3'd3 || in_ready !== 1'b1) begin miss++; $display("FAIL fullpop_post got lvl %0d rdy %b want 3/1", level, in_ready); end
    vec++; if (sh_a !== 8'hA7 || sh_amt !== 3'd7) begin miss++; $display("FAIL fullpop_head got %h/%0d want A7/7", sh_a, sh_amt); end
  endtask

  task automatic test_flush();
    flush = 1'b1; in_valid = 1'b1; in_data = 8'h77; in_amt = 3'd2; out_ready = 1'b1;
    vec++; if (in_ready !== 1'b1) begin miss++; $display("FAIL flush_in_ready got %b want 1", in_ready); end
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    vec++; if (level !== 3'd0 || out_valid !== 1'b0) begin miss++; $display("FAIL flush_clear got lvl %0d vld %b want 0/0", level, out_valid); end
    in_valid = 1'b1; in_data = 8'hA5; in_amt = 3'd4;
    step();
    in_valid = 1'b0;
    vec++; if (sh_a !== 8'hA5 || sh_amt !== 3'd4 || level !== 3'd1) begin miss++; $display("FAIL flush_push got %h/%0d lvl %0d want A5/4/1", sh_a, sh_amt, level); end
    vec++; if (rol8(sh_a, sh_amt) !== 8'h5A) begin miss++; $display("FAIL flush_rot got %h want 5A", rol8(sh_a, sh_amt)); end
  endtask

  task automatic test_async_reset();
    in_valid = 1'b1; in_data = 8'h3C; in_amt = 3'd3;
    step();
    in_valid = 1'b0;
    vec++; if (level !== 3'd2) begin miss++; $display("FAIL areset_pre got %0d want 2", level); end
    #2;
    reset_n = 1'b0;
    #1;
    vec++; if (out_valid !== 1'b0 || level !== 3'd0 || in_ready !== 1'b1) begin miss++; $display("FAIL areset_now got vld %b lvl %0d rdy %b want 0/0/1", out_valid, level, in_ready); end
    vec++; if (sh_a !== 8'h00 || sh_amt !== 3'd0) begin miss++; $display("FAIL areset_head got %h/%0d want 00/0", sh_a, sh_amt); end
    #1;
    reset_n = 1'b1;
    step();
    vec++; if (level !== 3'd0 || out_valid !== 1'b0) begin miss++; $display("FAIL areset_after got lvl %0d vld %b want 0/0", level, out_valid); end
  endtask

  initial begin
    vec = 0;
    miss = 0;
    test_reset();
    test_basic();
    test_fill();
    test_simultaneous();
    test_full_pop();
    test_flush();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule

// File: doc/rot_cmd_fifo.md
Name: rot_cmd_fifo

Overview:
Show-ahead command queue that sits directly upstream of the 8-bit combinational rotate-left stage. It buffers {operand, rotate amount} commands from a producer over a valid/ready handshake. The head entry drives the rotate stage's a/amt inputs combinationally, so the rotated result is valid in the same cycle as out_valid. The consumer pops an entry by asserting out_ready, and a synchronous flush empties the queue.

Parameters:
DEPTH, 4, number of entries; power of 2, minimum 2
ADDR_W, 2, pointer width; must equal log2(DEPTH)

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
flush  in  1  synchronous clear of queue contents
in_valid  in  1  producer presents a command
in_ready  out  1  queue can accept a command
in_data  in  8  operand to be rotated
in_amt  in  3  rotate-left amount, 0..7
out_valid  out  1  head entry valid (queue not empty)
out_ready  in  1  consumer accepts the head entry
sh_a  out  8  head operand, drives rotate stage input a
sh_amt  out  3  head amount, drives rotate stage input amt
level  out  ADDR_W+1  current occupancy, 0..DEPTH

Behaviour:
- Reset (reset_n=0, asynchronous): rd_ptr=0, wr_ptr=0, count=0.
  - Resulting outputs: out_valid=0, in_ready=1, level=0, sh_a=0, sh_amt=0.
  - Reset takes effect immediately, including mid-transfer; any queued commands are lost.
  - Storage array is not reset.
- Handshake definitions:
  - push = in_valid & in_ready
  - pop = out_valid & out_ready
  - in_ready = (count != DEPTH), combinational from state only; it never depends on out_ready.
  - out_valid = (count != 0).
- Push: mem[wr_ptr] <= {in_amt, in_data}; wr_ptr increments.
- Pop: rd_ptr increments.
- Pointers are ADDR_W bits and wrap modulo DEPTH with no special-casing.
- Count update:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged, and both pointers advance.
- Full (count=DEPTH): in_ready=0, so in_valid is ignored and the producer must hold its data. No write is performed even if a pop happens in the same cycle; the freed slot is visible as in_ready=1 on the next cycle.
- Empty (count=0): out_ready is ignored and no pop occurs. sh_a and sh_amt are forced to 0, so the rotate stage output is 0x00.
- Latency: a command pushed in cycle N appears on sh_a/sh_amt with out_valid=1 in cycle N+1. There is no same-cycle bypass.
- Head outputs: sh_a = mem[rd_ptr][7:0] and sh_amt = mem[rd_ptr][10:8] when not empty. They are combinational from registered state and stable while out_valid=1 and out_ready=0.
- Flush=1 at a clock edge:
  - rd_ptr, wr_ptr and count go to 0.
  - Any push or pop in the same cycle is discarded, so flush has priority.
  - in_ready stays as computed from pre-flush state during that cycle.
- level = count, registered.
- Commands are returned strictly in FIFO order; amt values are passed through unchanged (0..7, no range check needed).

Test Plan:
- Basic: reset, push {0x81, amt 1} -> next cycle out_valid=1, sh_a=0x81, sh_amt=1, rotate stage y=0x03, level=1. Pop -> out_valid=0, sh_a=0x00, level=0.
- Fill/full: push 0x01, 0x02, 0x04, 0x08 (amt 0..3) with out_ready=0 -> level=4, in_ready=0. A fifth in_valid with 0xFF is not accepted. Drain -> heads appear in order 0x01/0, 0x02/1, 0x04/2, 0x08/3, giving rotate outputs 0x01, 0x04, 0x10, 0x40.
- Simultaneous: at level=2, push and pop together for 6 cycles with incrementing data -> level stays 2, pointers wrap past DEPTH, output order is preserved.
- Full plus pop: at level=4, assert out_ready and in_valid together -> one pop, no push, level=3, in_ready=1 the next cycle.
- Flush: at level=3, assert flush together with in_valid and out_ready -> next cycle level=0, out_valid=0. A subsequent push of 0xA5/amt 4 appears as head, with rotate y=0x5A.
- Async reset mid-operation: at level=2, pulse reset_n low between clock edges -> out_valid=0, level=0, in_ready=1 immediately, without waiting for a clock edge.
